// File: rtl/man_jump_release_if.sv
// Signal bundle between the game FSM / squeeze block (master) and the jump release unit (slave).
interface man_jump_release_if;
    logic [2:0] state;
    logic [2:0] i_squeeze_lvl;
    logic [2:0] o_release_man;
    logic [9:0] o_jump_dx;
    logic [7:0] o_jump_dy;
    logic       o_busy;
    logic       o_jump_done;

    modport master (
        output state, i_squeeze_lvl,
        input  o_release_man, o_jump_dx, o_jump_dy, o_busy, o_jump_done
    );

    modport slave (
        input  state, i_squeeze_lvl,
        output o_release_man, o_jump_dx, o_jump_dy, o_busy, o_jump_done
    );
endinterface

// File: rtl/man_jump_release.sv
// Release side of the charge/jump mechanic: latches the squeeze charge on entry to the jump
// state, unwinds the sprite squeeze and drives a registered parabolic (dx, dy) trajectory.
//
// state | meaning
// IDLE  | waiting for a fresh entry into the jump state; dx holds, dy and sprite level are 0
// LOAD  | one cycle: latch charge, clear frame/prescaler/trajectory
// FLY   | advance one frame per prescaler wrap, recompute trajectory
// DONE  | one cycle after landing; raises the done pulse, returns to IDLE
module man_jump_release #(
    parameter logic [2:0] ST_JUMP  = 3'd4,
    parameter int         TICK_W   = 19,
    parameter int         FRAMES   = 16,
    parameter int         DX_UNIT  = 4,
    parameter int         DY_SHIFT = 0
) (
    input logic               clk_machine,
    input logic               rst_machine,
    man_jump_release_if.slave jif
);

    typedef enum logic [1:0] {IDLE, LOAD, FLY, DONE} fsm_t;

    fsm_t              fsm;
    logic              prev_is_jump;
    logic [2:0]        charge;
    logic [4:0]        frame;
    logic [TICK_W-1:0] presc;
    logic [2:0]        release_man;
    logic [9:0]        dx;
    logic [7:0]        dy;
    logic              busy;
    logic              done;

    logic              is_jump;
    logic              launch;
    logic              tick;
    logic [4:0]        frame_nx;
    logic [9:0]        dx_nx;
    logic [7:0]        dy_nx;

    assign is_jump  = (jif.state == ST_JUMP);
    assign launch   = is_jump && !prev_is_jump;
    assign tick     = &presc;
    assign frame_nx = frame + 5'd1;

    // Products are formed at 16 bits, then truncated to the output widths.
    assign dx_nx = 10'(16'(frame_nx) * (16'(charge) + 16'd1) * 16'(DX_UNIT));
    assign dy_nx = 8'((16'(frame_nx) * (16'(FRAMES) - 16'(frame_nx))) >> DY_SHIFT);

    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            fsm          <= IDLE;
            prev_is_jump <= 1'b1;
            charge       <= 3'd0;
            frame        <= 5'd0;
            presc        <= '0;
            release_man  <= 3'd0;
            dx           <= 10'd0;
            dy           <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            prev_is_jump <= is_jump;
            done         <= 1'b0;
            case (fsm)
                IDLE: begin
                    dy          <= 8'd0;
                    release_man <= 3'd0;
                    if (launch) begin
                        fsm  <= LOAD;
                        busy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!is_jump) begin
                        fsm         <= IDLE;
                        busy        <= 1'b0;
                        dx          <= 10'd0;
                        dy          <= 8'd0;
                        release_man <= 3'd0;
                    end else begin
                        charge      <= jif.i_squeeze_lvl;
                        release_man <= jif.i_squeeze_lvl;
                        frame       <= 5'd0;
                        presc       <= '0;
                        dx          <= 10'd0;
                        dy          <= 8'd0;
                        fsm         <= FLY;
                    end
                end
                FLY: begin
                    if (!is_jump) begin
                        fsm         <= IDLE;
                        busy        <= 1'b0;
                        dx          <= 10'd0;
                        dy          <= 8'd0;
                        release_man <= 3'd0;
                    end else begin
                        presc <= presc + TICK_W'(1);
                        if (tick) begin
                            frame       <= frame_nx;
                            release_man <= (release_man == 3'd0) ? 3'd0 : release_man - 3'd1;
                            dx          <= dx_nx;
                            dy          <= dy_nx;
                            if (frame_nx == 5'(FRAMES))
                                fsm <= DONE;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    fsm  <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign jif.o_release_man = release_man;
    assign jif.o_jump_dx     = dx;
    assign jif.o_jump_dy     = dy;
    assign jif.o_busy        = busy;
    assign jif.o_jump_done   = done;

endmodule
